bb_write_ctrl: RTL and testbench
================================

Name: bb_write_ctrl

Overview:
- Consumes the 8-bit back-buffer control byte driven by the processor's bb_we PIO output, and arbitrates all writes into the double-buffered framebuffer.
- Gates rasterizer pixel writes into the current back buffer.
- Runs hardware clear sweeps of the back buffer.
- Performs front/back buffer swaps aligned to vsync.
- Sits between the PIO/rasterizer and the framebuffer memory write port.

Parameters:
ADDR_W, 17, pixel address width within one buffer
DATA_W, 8, pixel data width (DATA_W >= 4)
NUM_PIXELS, 76800, pixels per buffer; clear sweep covers addresses 0..NUM_PIXELS-1

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
ctrl_in  in  8  PIO control byte: [0]=WE, [1]=CLEAR, [2]=SWAP, [3]=reserved (ignored), [7:4]=clear colour
vsync  in  1  vertical sync from display timing, synchronous to clk
px_valid  in  1  rasterizer pixel valid
px_addr  in  ADDR_W  rasterizer pixel address
px_data  in  DATA_W  rasterizer pixel data
px_ready  out  1  pixel accepted this cycle
mem_we  out  1  framebuffer write request
mem_addr  out  ADDR_W+1  {buffer index, pixel address}
mem_wdata  out  DATA_W  write data
mem_ready  in  1  memory accepts the write this cycle
front_sel  out  1  buffer currently displayed
busy  out  1  clear or swap in progress or pending
swap_count  out  8  number of completed swaps, wraps 255->0

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, named reset. All state updates on the rising edge of clk.
- Reset values: state=IDLE, front_sel=0, swap_count=0, clr_cnt=0, clear_pend=0, swap_pend=0, ctrl_d=0, vsync_d=0, busy=0, mem_we=0, px_ready=0.
- Edge detection: ctrl_d<=ctrl_in and vsync_d<=vsync every cycle.
  - clr_edge = ctrl_in[1]&~ctrl_d[1]; swp_edge = ctrl_in[2]&~ctrl_d[2]; vs_edge = vsync&~vsync_d.
  - A bit already high when reset releases produces an edge on the first cycle after reset.
- Back buffer index: bb = ~front_sel. mem_addr[ADDR_W] = bb in every state.
- Memory handshake: a write completes in a cycle where mem_we&mem_ready. mem_addr and mem_wdata stay stable while mem_we=1 and mem_ready=0.
- Pending flags: clr_edge sets clear_pend and swp_edge sets swap_pend, in any state. A flag clears when its operation starts.
- IDLE:
  - mem_we = px_valid&ctrl_in[0]; px_ready = mem_ready&ctrl_in[0].
  - mem_addr[ADDR_W-1:0] = px_addr; mem_wdata = px_data.
  - With WE=0, the rasterizer stalls (px_ready=0).
  - Next state, in priority order:
    - clear_pend or clr_edge: go to CLEAR. Latch clr_colour = ctrl_in[7:4], zero-extended to DATA_W. clr_cnt=0.
    - else swap_pend or swp_edge: go to SWAP_WAIT.
  - A pixel accepted in the same cycle as the transition still completes.
- CLEAR:
  - px_ready=0; mem_we=1; mem_addr low = clr_cnt; mem_wdata = clr_colour.
  - clr_cnt increments on each accepted write.
  - On acceptance at clr_cnt=NUM_PIXELS-1: clr_cnt<=0. Go to SWAP_WAIT if swap_pend, else IDLE.
  - Writes total exactly NUM_PIXELS. Stalls on mem_ready=0 hold clr_cnt.
  - clr_edge during CLEAR sets clear_pend, so another full clear runs later.
- SWAP_WAIT:
  - px_ready=0; mem_we=0.
  - On vs_edge: front_sel toggles, swap_count+1 mod 256, swap_pend=0. Go to CLEAR if clear_pend (the clear targets the new back buffer), else IDLE.
  - A vsync already high on entry does not trigger; the swap waits for the next rising edge.
- Simultaneous clr_edge and swp_edge in IDLE: clear first, then swap.
- busy = (state!=IDLE) | clear_pend | swap_pend. This is a combinational decode of registers.
- Reset asserted mid-CLEAR or mid-SWAP_WAIT: return to reset values next cycle; the operation is abandoned and front_sel returns to 0.

Test Plan (NUM_PIXELS=16, ADDR_W=4, DATA_W=8):
- Reset, ctrl_in=0x01, mem_ready=1, px_valid=1, px_addr=5, px_data=0xAB -> same cycle mem_we=1, mem_addr=0x15, mem_wdata=0xAB, px_ready=1. Then ctrl_in=0x00 -> px_ready=0, mem_we=0.
- ctrl_in 0x00->0x32, mem_ready=1 -> 16 consecutive writes, addr 0x10..0x1F, data 0x03; busy=1 throughout; IDLE afterwards. Toggling mem_ready 0/1 mid-sweep -> still exactly 16 writes with no skipped or duplicated address.
- ctrl_in 0x00->0x04 with vsync high on entry -> no swap until vsync falls and rises again. Then front_sel=1, swap_count=1, and subsequent pixel writes target mem_addr[4]=0.
- ctrl_in 0x00->0x56 in one cycle -> 16 clear writes with data 0x05, then SWAP_WAIT, then swap on the next vsync rising edge; busy drops the cycle after the swap.
- In SWAP_WAIT pulse CLEAR, then vsync rises -> swap, then clear of the new back buffer. Reset asserted mid-clear -> next cycle mem_we=0, front_sel=0, swap_count=0, busy=0.
- 256 swaps -> swap_count wraps to 0; front_sel=0 after an even number of swaps.

Source files
------------

// File: rtl/bb_write_ctrl.sv
// Back-buffer write arbiter: pixel gating, hardware clear sweeps and
// vsync-aligned front/back swaps for a double-buffered framebuffer.
module bb_write_ctrl #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 8,
  parameter int NUM_PIXELS = 76800
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        ctrl_in,
  input  logic              vsync,
  input  logic              px_valid,
  input  logic [ADDR_W-1:0] px_addr,
  input  logic [DATA_W-1:0] px_data,
  output logic              px_ready,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              front_sel,
  output logic              busy,
  output logic [7:0]        swap_count
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CLEAR = 2'd1;
  localparam logic [1:0] S_SWAP  = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_PX = ADDR_W'(NUM_PIXELS - 1);

  logic [1:0]        state_q, state_d;
  logic              front_q, front_d;
  logic [7:0]        swaps_q, swaps_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] colour_q, colour_d;
  logic              cpend_q, cpend_d;
  logic              spend_q, spend_d;
  logic [1:0]        ctrl_prev_q, ctrl_prev_d;
  logic              vs_prev_q, vs_prev_d;

  logic              clr_edge, swp_edge, vs_edge;
  logic [DATA_W-1:0] ctrl_colour;
  logic [ADDR_W-1:0] addr_lo;
  logic              unused_rsvd;

  assign clr_edge    = ctrl_in[1] & ~ctrl_prev_q[0];
  assign swp_edge    = ctrl_in[2] & ~ctrl_prev_q[1];
  assign vs_edge     = vsync & ~vs_prev_q;
  assign ctrl_colour = DATA_W'(ctrl_in[7:4]);
  assign unused_rsvd = ctrl_in[3];

  assign ctrl_prev_d = ctrl_in[2:1];
  assign vs_prev_d   = vsync;

  always_comb begin
    state_d   = state_q;
    front_d   = front_q;
    swaps_d   = swaps_q;
    cnt_d     = cnt_q;
    colour_d  = colour_q;
    cpend_d   = cpend_q | clr_edge;
    spend_d   = spend_q | swp_edge;
    mem_we    = 1'b0;
    px_ready  = 1'b0;
    addr_lo   = px_addr;
    mem_wdata = px_data;
    unique case (state_q)
      S_IDLE: begin
        mem_we   = px_valid & ctrl_in[0];
        px_ready = mem_ready & ctrl_in[0];
        if (cpend_q | clr_edge) begin
          state_d  = S_CLEAR;
          colour_d = ctrl_colour;
          cnt_d    = '0;
          cpend_d  = 1'b0;
        end else if (spend_q | swp_edge) begin
          state_d = S_SWAP;
        end
      end
      S_CLEAR: begin
        mem_we    = 1'b1;
        addr_lo   = cnt_q;
        mem_wdata = colour_q;
        if (mem_ready) begin
          if (cnt_q == LAST_PX) begin
            cnt_d   = '0;
            state_d = spend_q ? S_SWAP : S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_SWAP: begin
        if (vs_edge) begin
          front_d = ~front_q;
          swaps_d = swaps_q + 8'd1;
          spend_d = swp_edge;
          // pending clear targets the buffer that just became the back one
          if (cpend_q) begin
            state_d  = S_CLEAR;
            colour_d = ctrl_colour;
            cnt_d    = '0;
            cpend_d  = clr_edge;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      front_q     <= 1'b0;
      swaps_q     <= 8'd0;
      cnt_q       <= '0;
      colour_q    <= '0;
      cpend_q     <= 1'b0;
      spend_q     <= 1'b0;
      ctrl_prev_q <= 2'b00;
      vs_prev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      front_q     <= front_d;
      swaps_q     <= swaps_d;
      cnt_q       <= cnt_d;
      colour_q    <= colour_d;
      cpend_q     <= cpend_d;
      spend_q     <= spend_d;
      ctrl_prev_q <= ctrl_prev_d;
      vs_prev_q   <= vs_prev_d;
    end
  end

  assign mem_addr   = {~front_q, addr_lo};
  assign front_sel  = front_q;
  assign swap_count = swaps_q;
  assign busy       = (state_q != S_IDLE) | cpend_q | spend_q;

endmodule

// File: tb/tb_bb_write_ctrl.sv
// Bench for bb_write_ctrl: directed scenarios plus random traffic,
// every cycle compared against a queue-based behavioural model.
module tb_bb_write_ctrl;
  localparam int AW = 4;
  localparam int DW = 8;
  localparam int NP = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    ctrl_in;
  logic          vsync;
  logic          px_valid;
  logic [AW-1:0] px_addr;
  logic [DW-1:0] px_data;
  logic          mem_ready;
  logic          px_ready;
  logic          mem_we;
  logic [AW:0]   mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          front_sel;
  logic          busy;
  logic [7:0]    swap_count;

  always #5 clk = ~clk;

  bb_write_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_PIXELS(NP)) dut (
    .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .vsync(vsync),
    .px_valid(px_valid), .px_addr(px_addr), .px_data(px_data),
    .px_ready(px_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .front_sel(front_sel), .busy(busy), .swap_count(swap_count)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: pending clear writes live in a queue of {addr,data}
  bit                  m_front;
  int                  m_count;
  bit                  m_cpend, m_spend, m_wait;
  logic [7:0]          m_pctrl;
  bit                  m_pvs;
  logic [AW+DW-1:0]    m_q[$];

  task automatic m_reset();
    m_front = 0; m_count = 0; m_cpend = 0; m_spend = 0; m_wait = 0;
    m_pctrl = 8'h00; m_pvs = 0;
    m_q.delete();
  endtask

  task automatic m_fill(input logic [3:0] col);
    m_q.delete();
    for (int i = 0; i < NP; i++) begin
      logic [AW-1:0] a;
      logic [DW-1:0] d;
      a = AW'(i);
      d = DW'(col);
      m_q.push_back({a, d});
    end
  endtask

  task automatic model_cycle();
    bit clearing, idle, e_we, e_rdy, e_busy, ce, se, ve, sp_old;
    logic [AW:0]   ea;
    logic [DW-1:0] ed;
    clearing = (m_q.size() > 0);
    idle     = !clearing && !m_wait;
    e_we     = clearing ? 1'b1 : (idle ? (px_valid & ctrl_in[0]) : 1'b0);
    e_rdy    = idle & mem_ready & ctrl_in[0];
    e_busy   = clearing | m_wait | m_cpend | m_spend;
    chk("mem_we", mem_we, e_we);
    chk("px_ready", px_ready, e_rdy);
    chk("busy", busy, e_busy);
    chk("front_sel", front_sel, m_front);
    chk("swap_count", swap_count, m_count);
    if (e_we) begin
      if (clearing) begin
        ea = {~m_front, m_q[0][AW+DW-1:DW]};
        ed = m_q[0][DW-1:0];
      end else begin
        ea = {~m_front, px_addr};
        ed = px_data;
      end
      chk("mem_addr", mem_addr, ea);
      chk("mem_wdata", mem_wdata, ed);
    end
    ce = ctrl_in[1] & ~m_pctrl[1];
    se = ctrl_in[2] & ~m_pctrl[2];
    ve = vsync & ~m_pvs;
    if (reset) begin
      m_reset();
    end else begin
      if (clearing) begin
        sp_old = m_spend;
        m_cpend |= ce;
        m_spend |= se;
        if (mem_ready) begin
          void'(m_q.pop_front());
          if (m_q.size() == 0) m_wait = sp_old;
        end
      end else if (m_wait) begin
        if (ve) begin
          m_front = ~m_front;
          m_count = (m_count + 1) % 256;
          m_wait  = 0;
          m_spend = se;
          if (m_cpend) m_fill(ctrl_in[7:4]);
          m_cpend = ce;
        end else begin
          m_cpend |= ce;
          m_spend |= se;
        end
      end else begin
        if (m_cpend | ce) begin
          m_fill(ctrl_in[7:4]);
          m_cpend = 0;
          m_spend |= se;
        end else if (m_spend | se) begin
          m_wait  = 1;
          m_spend = 1;
        end
      end
      m_pctrl = ctrl_in;
      m_pvs   = vsync;
    end
  endtask

  task automatic step(input bit r, input logic [7:0] c, input bit vs,
                      input bit pv, input logic [AW-1:0] pa,
                      input logic [DW-1:0] pd, input bit mr);
    @(negedge clk);
    reset = r; ctrl_in = c; vsync = vs; px_valid = pv;
    px_addr = pa; px_data = pd; mem_ready = mr;
    #2;
    model_cycle();
  endtask

  int k;
  logic [7:0] rc;
  bit rv;

  initial begin
    reset = 1; ctrl_in = 0; vsync = 0; px_valid = 0;
    px_addr = 0; px_data = 0; mem_ready = 0;
    m_reset();
    step(1, 8'h00, 0, 0, 0, 0, 0);
    step(1, 8'h00, 0, 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 0, 0, 1);
    chk("rst_busy", busy, 0);
    chk("rst_front", front_sel, 0);
    chk("rst_count", swap_count, 0);

    // pixel write gated by WE
    step(0, 8'h01, 0, 1, 4'd5, 8'hAB, 1);
    chk("px_we", mem_we, 1);
    chk("px_addr", mem_addr, 5'h15);
    chk("px_data", mem_wdata, 8'hAB);
    chk("px_rdy", px_ready, 1);
    step(0, 8'h00, 0, 1, 4'd5, 8'hAB, 1);
    chk("px_stall_rdy", px_ready, 0);
    chk("px_stall_we", mem_we, 0);

    // clear sweep with stalls
    k = 0;
    for (int i = 0; i < 60; i++) begin
      step(0, 8'h32, 0, 1, 4'($urandom), 8'($urandom), (i % 3) != 1);
      if (mem_we && mem_ready) begin
        chk("clr_addr", mem_addr, 32'h10 + k);
        chk("clr_data", mem_wdata, 8'h03);
        k++;
      end
      if (i > 0 && k < NP) chk("clr_busy", busy, 1);
    end
    chk("clr_writes", k, NP);
    chk("clr_done_busy", busy, 0);

    // swap waits for a fresh vsync rising edge
    step(0, 8'h00, 1, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 8'h04, 1, 0, 0, 0, 1);
    chk("sw_hold_front", front_sel, 0);
    chk("sw_hold_busy", busy, 1);
    for (int i = 0; i < 3; i++) step(0, 8'h04, 0, 0, 0, 0, 1);
    chk("sw_low_front", front_sel, 0);
    step(0, 8'h04, 1, 0, 0, 0, 1);
    step(0, 8'h01, 1, 1, 4'd7, 8'h5A, 1);
    chk("sw_front", front_sel, 1);
    chk("sw_count", swap_count, 1);
    chk("sw_px_addr", mem_addr, 5'h07);
    chk("sw_busy", busy, 0);

    // simultaneous clear+swap: clear first
    step(0, 8'h00, 0, 0, 0, 0, 1);
    k = 0;
    for (int i = 0; i < 18; i++) begin
      step(0, 8'h56, 0, 0, 0, 0, 1);
      if (mem_we && mem_ready) begin
        chk("cs_data", mem_wdata, 8'h05);
        k++;
      end
    end
    chk("cs_writes", k, NP);
    chk("cs_wait_busy", busy, 1);
    chk("cs_wait_we", mem_we, 0);
    step(0, 8'h56, 1, 0, 0, 0, 1);
    step(0, 8'h56, 1, 0, 0, 0, 1);
    chk("cs_busy_drop", busy, 0);
    chk("cs_front", front_sel, 0);
    chk("cs_count", swap_count, 2);

    // clear requested while waiting for vsync, then reset mid-clear
    step(0, 8'h00, 0, 0, 0, 0, 1);
    step(0, 8'h04, 0, 0, 0, 0, 1);
    step(0, 8'h02, 0, 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0, 0, 1);
    step(0, 8'h00, 1, 0, 0, 0, 1);
    chk("wc_front", front_sel, 1);
    chk("wc_count", swap_count, 3);
    chk("wc_addr0", mem_addr, 5'h00);
    step(0, 8'h00, 1, 0, 0, 0, 1);
    chk("wc_addr1", mem_addr, 5'h01);
    step(1, 8'h00, 0, 0, 0, 0, 1);
    step(0, 8'h00, 0, 0, 0, 0, 1);
    chk("mr_we", mem_we, 0);
    chk("mr_front", front_sel, 0);
    chk("mr_count", swap_count, 0);
    chk("mr_busy", busy, 0);

    // swap counter wrap
    for (int i = 0; i < 256; i++) begin
      step(0, 8'h04, 0, 0, 0, 0, 1);
      step(0, 8'h04, 0, 0, 0, 0, 1);
      step(0, 8'h04, 1, 0, 0, 0, 1);
      step(0, 8'h00, 0, 0, 0, 0, 1);
      if (i == 254) chk("wrap_255", swap_count, 255);
    end
    chk("wrap_count", swap_count, 0);
    chk("wrap_front", front_sel, 0);

    // random traffic
    rc = 8'h00;
    rv = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) rc = 8'($urandom);
      if ($urandom_range(0, 5) == 0) rv = ~rv;
      step($urandom_range(0, 599) == 0, rc, rv, 1'($urandom),
           4'($urandom), 8'($urandom), $urandom_range(0, 3) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
